rv32_lsu: RTL and testbench
===========================

# rv32_lsu

Load/store unit for the shrv32 core: the initiator side of the single-port, byte-enabled data-RAM interface (address, byte enables, write data, write enable, registered read data with one cycle of latency). Accepts one RV32I load or store per handshake from the execute stage. Drives a single RAM access with correct lane placement and byte enables, extracts and sign/zero-extends load data, and returns a result or an alignment/encoding error to writeback.

## Interface
- `MEM_WORD_ADDR`, default 0: 0 drives `mem_address` as a word-aligned byte address (`{addr[31:2],2'b00}`); 1 drives `{2'b00,addr[31:2]}`.
- `clock` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: high only in IDLE.
- `req_store` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RV32I width code: 0 B, 1 H, 2 W, 4 BU, 5 HU.
- `req_address` input 32: byte address, already computed (rs1+imm).
- `req_wdata` input 32: store data (rs2), right-aligned.
- `resp_valid` output 1: result present; held until accepted.
- `resp_ready` input 1: consumer accepts the response.
- `resp_rdata` output 32: extended load data; 0 for stores and errors.
- `resp_error` output 1: misaligned or illegal funct3.
- `mem_address` output 32: RAM address.
- `mem_byteena` output 4: lane enables. Lane i is `mem_data[8i+7:8i]`.
- `mem_data` output 32: lane-placed write data.
- `mem_wren` output 1: write strobe, high for exactly one cycle per store.
- `mem_q` input 32: RAM read data, registered by the RAM; valid the cycle after the address is presented.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Request fields are captured into registers on accept (`req_valid && req_ready`).
- **Decode at accept:**
  - Legal load funct3: {0,1,2,4,5}. Legal store funct3: {0,1,2}.
  - Misaligned: H/HU with `addr[0]=1`, or W with `addr[1:0]!=0`.
  - Illegal or misaligned: go to RESP with `resp_error=1`, `resp_rdata=0`. No RAM cycle is issued.
  - Otherwise go to ISSUE.
- **ISSUE:** drive `mem_address` from the captured address.
  - Store: `mem_wren=1`; `mem_data = wdata << (8*addr[1:0])`.
  - Store byte enables: B = `4'b0001<<addr[1:0]`; H = `4'b0011<<addr[1:0]`; W = `4'b1111`.
  - Store then goes to RESP.
  - Load: `mem_wren=0`, `mem_byteena=0`, `mem_data=0`. Zero enables are mandatory: the RAM forwards write data on enabled lanes even on reads. Load then goes to WAIT.
- **WAIT (loads only):** sample `mem_q`. Shift right by `8*addr[1:0]`.
  - B/H: sign-extend from bit 7/15.
  - BU/HU: zero-extend.
  - W: pass through.
  - Register the result into `resp_rdata`, then go to RESP.
- **RESP:** `resp_valid=1`. Outputs stay stable until `resp_ready`, then go to IDLE.
- **mem_\* defaults:** in every state other than ISSUE, all `mem_*` outputs are 0, except `mem_address`, which holds its last value.
- **Reset:**
  - All state returns to IDLE.
  - `req_ready=1`. `resp_valid`, `resp_error`, `resp_rdata`, `mem_wren`, `mem_byteena`, `mem_data` and `mem_address` are all 0.
  - Reset asserted in ISSUE cancels the write: `mem_wren` is 0 from the next cycle. An in-flight load result is discarded.

## Timing
- Accept at edge 0. ISSUE during cycle 1.
- Store: `resp_valid` from cycle 2.
- Load: WAIT in cycle 2; `resp_valid` from cycle 3.
- Error: `resp_valid` from cycle 1.
- One outstanding request; no pipelining. Throughput: a load takes 4 cycles and a store 3 when `resp_ready` stays high.
- `req_ready` is low from the cycle after accept until the cycle after the response handshake. A request presented in the same cycle as `resp_ready` is not accepted.
- `resp_valid` holding with `resp_ready=0` is unbounded; no RAM activity occurs while held.

## Test plan
- SB, addr `0x0000_0003`, wdata `0x0000_00A5` -> ISSUE cycle: `mem_byteena=4'b1000`, `mem_data=0xA500_0000`, `mem_wren=1` for exactly 1 cycle; `resp_valid` 2 cycles after accept, `resp_error=0`.
- LH, addr `0x...2`, `mem_q=0x8001_1234` -> `mem_byteena=0`, `mem_wren=0`; `resp_rdata=0xFFFF_8001`. Same access as LHU -> `0x0000_8001`. LB at offset 1 -> `0x0000_0012`.
- SW `0xDEAD_BEEF` to addr 8, then LW addr 8 against a behavioural byte-enabled RAM model -> `resp_rdata=0xDEAD_BEEF`. Then SH `0x1111` to addr 10; LW addr 8 -> `0x1111_BEEF`.
- LW addr `0x...6`, SH addr `0x...1`, load funct3=3, store funct3=4 -> each gives `resp_error=1` 1 cycle after accept, `resp_rdata=0`, and `mem_wren` never asserted.
- Hold `resp_ready=0` for 5 cycles after a load -> `resp_valid` and `resp_rdata` stable, `req_ready=0`, no `mem_wren`; release -> IDLE next cycle.
- Assert `reset` during the ISSUE cycle of a store, and separately during WAIT of a load -> next cycle all outputs at reset values, `req_ready=1`, no `resp_valid` produced.

Source files
------------

// File: rtl/rv32_lsu.sv
// rv32_lsu: RV32I load/store unit driving a single-port,
// byte-enabled data RAM with one cycle of read latency.
module rv32_lsu #(
  parameter bit MEM_WORD_ADDR = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_byteena,
  output logic [31:0] mem_data,
  output logic        mem_wren,
  input  logic [31:0] mem_q
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  state_t state, state_nx;

  logic        store_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        accept;
  logic        legal;
  logic        misal;
  logic        bad;
  logic [31:0] shifted;
  logic [31:0] ext;

  assign accept = req_valid && req_ready;

  // Decode legality and alignment of the request being offered
  always_comb begin
    legal = 1'b0;
    misal = 1'b0;
    if (req_store)
      legal = req_funct3 inside {3'd0, 3'd1, 3'd2};
    else
      legal = req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    unique case (1'b1)
      (req_funct3[1:0] == 2'd1):
        misal = req_address[0];
      (req_funct3[1:0] == 2'd2):
        misal = req_address[1:0] != 2'b00;
      default:
        misal = 1'b0;
    endcase
    bad = !legal || misal;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (accept) state_nx = bad ? RESP : ISSUE;
      ISSUE:
        state_nx = store_q ? RESP : WAIT;
      WAIT:
        state_nx = RESP;
      RESP:
        if (resp_ready) state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  // Capture request fields on accept
  always_ff @(posedge clock) begin
    if (reset) begin
      store_q <= 1'b0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      store_q <= req_store;
      f3_q    <= req_funct3;
      off_q   <= req_address[1:0];
      wdata_q <= req_wdata;
    end
  end

  // RAM address holds between accesses; loaded only for real accesses
  always_ff @(posedge clock) begin
    if (reset)
      mem_address <= 32'd0;
    else if (accept && !bad)
      mem_address <= MEM_WORD_ADDR ?
        {2'b00, req_address[31:2]} :
        {req_address[31:2], 2'b00};
  end

  // Lane-extract and extend the RAM word
  always_comb begin
    shifted = mem_q >> {off_q, 3'b000};
    unique case (f3_q)
      3'd0:    ext = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    ext = {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    ext = {24'd0, shifted[7:0]};
      3'd5:    ext = {16'd0, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  // Response registers: cleared on accept, filled in WAIT
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_error <= 1'b0;
      resp_rdata <= 32'd0;
    end else if (accept) begin
      resp_error <= bad;
      resp_rdata <= 32'd0;
    end else if (state == WAIT) begin
      resp_rdata <= ext;
    end
  end

  // Handshake and RAM strobes; lanes stay dark on loads
  always_comb begin
    req_ready   = state == IDLE;
    resp_valid  = state == RESP;
    mem_wren    = 1'b0;
    mem_byteena = 4'b0000;
    mem_data    = 32'd0;
    if (state == ISSUE && store_q) begin
      mem_wren = 1'b1;
      mem_data = wdata_q << {off_q, 3'b000};
      unique case (f3_q[1:0])
        2'd0:    mem_byteena = 4'b0001 << off_q;
        2'd1:    mem_byteena = 4'b0011 << off_q;
        default: mem_byteena = 4'b1111;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_lsu.sv
// tb_rv32_lsu: directed plus random load/store traffic
// against a byte-array memory reference.
module tb_rv32_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [3:0]  mem_byteena;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q = 32'd0;

  int cmp = 0;
  int err = 0;

  logic [7:0] ram [256];
  logic [7:0] refm [256];

  rv32_lsu #(.MEM_WORD_ADDR(1'b0)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3),
    .req_address(req_address), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_address(mem_address), .mem_byteena(mem_byteena),
    .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  // Byte-enabled RAM with registered read data
  always @(posedge clock) begin
    if (mem_wren)
      for (int i = 0; i < 4; i++)
        if (mem_byteena[i])
          ram[{mem_address[7:2], 2'(i)}] <= mem_data[8*i +: 8];
    mem_q <= {ram[{mem_address[7:2], 2'd3}],
              ram[{mem_address[7:2], 2'd2}],
              ram[{mem_address[7:2], 2'd1}],
              ram[{mem_address[7:2], 2'd0}]};
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, ".resp_error"}, 32'(resp_error), 32'd0);
    chk({tag, ".resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, ".mem_wren"}, 32'(mem_wren), 32'd0);
    chk({tag, ".mem_byteena"}, 32'(mem_byteena), 32'd0);
    chk({tag, ".mem_data"}, mem_data, 32'd0);
    chk({tag, ".mem_address"}, mem_address, 32'd0);
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit is_bad(input bit st,
                                input logic [2:0] f3,
                                input logic [31:0] a);
    bit ok;
    if (st) ok = (f3 <= 3'd2);
    else    ok = (f3 <= 3'd2) || f3 == 3'd4 || f3 == 3'd5;
    if (!ok) return 1'b1;
    return (a % size_of(f3)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                           input logic [31:0] a);
    logic [31:0] v = 32'd0;
    int n = size_of(f3);
    for (int k = 0; k < n; k++)
      v = v | (32'(refm[(int'(a[7:0]) + k) % 256]) << (8 * k));
    if (f3 < 3'd4 && n < 4 && v[8*n-1])
      v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  // One complete request/response; hold = cycles resp_ready is low
  task automatic run(input bit st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int hold, output logic [31:0] rd);
    bit bad = is_bad(st, f3, a);
    int n = size_of(f3);
    int off = int'(a[1:0]);
    logic [3:0] be = 4'd0;
    logic [31:0] exp_rd = 32'd0;
    int guard = 0;
    for (int k = 0; k < n; k++) be[off + k] = 1'b1;
    if (!st && !bad) exp_rd = ref_load(f3, a);
    while (!req_ready && guard < 20) begin
      step();
      guard++;
    end
    chk("idle_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_store = st;
    req_funct3 = f3;
    req_address = a;
    req_wdata = wd;
    resp_ready = (hold == 0);
    step();
    req_valid = 1'b0;
    if (bad) begin
      chk("err_valid", 32'(resp_valid), 32'd1);
      chk("err_flag", 32'(resp_error), 32'd1);
      chk("err_wren", 32'(mem_wren), 32'd0);
    end else begin
      chk("iss_valid", 32'(resp_valid), 32'd0);
      chk("iss_ready", 32'(req_ready), 32'd0);
      chk("iss_wren", 32'(mem_wren), 32'(st));
      chk("iss_addr", mem_address, {a[31:2], 2'b00});
      chk("iss_be", 32'(mem_byteena), st ? 32'(be) : 32'd0);
      chk("iss_data", mem_data, st ? (wd << (8 * off)) : 32'd0);
      if (st)
        for (int k = 0; k < n; k++)
          refm[(int'(a[7:0]) + k) % 256] = wd[8*k +: 8];
      step();
      chk("post_wren", 32'(mem_wren), 32'd0);
      if (!st) begin
        chk("wait_valid", 32'(resp_valid), 32'd0);
        chk("wait_be", 32'(mem_byteena), 32'd0);
        step();
      end
      chk("resp_valid", 32'(resp_valid), 32'd1);
      chk("resp_error", 32'(resp_error), 32'd0);
    end
    chk("resp_rdata", resp_rdata, exp_rd);
    rd = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, exp_rd);
      chk("hold_ready", 32'(req_ready), 32'd0);
      chk("hold_wren", 32'(mem_wren), 32'd0);
    end
    resp_ready = 1'b1;
    step();
    chk("back_idle", 32'(req_ready), 32'd1);
    chk("back_valid", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [2:0] f3tab [8];
    f3tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    reset = 1'b1;
    req_valid = 1'b0;
    req_store = 1'b0;
    req_funct3 = 3'd0;
    req_address = 32'd0;
    req_wdata = 32'd0;
    resp_ready = 1'b1;
    step();
    step();
    chk_reset_vals("rst");
    reset = 1'b0;
    step();

    for (int w = 0; w < 64; w++)
      run(1'b1, 3'd2, 32'(4 * w), $urandom, 0, rd);

    run(1'b1, 3'd0, 32'h3, 32'h0000_00A5, 0, rd);
    run(1'b1, 3'd2, 32'h10, 32'h8001_1234, 0, rd);
    run(1'b0, 3'd1, 32'h12, 32'd0, 0, rd);
    chk("lh", rd, 32'hFFFF_8001);
    run(1'b0, 3'd5, 32'h12, 32'd0, 0, rd);
    chk("lhu", rd, 32'h0000_8001);
    run(1'b0, 3'd0, 32'h11, 32'd0, 0, rd);
    chk("lb", rd, 32'h0000_0012);
    run(1'b1, 3'd2, 32'h8, 32'hDEAD_BEEF, 0, rd);
    run(1'b0, 3'd2, 32'h8, 32'd0, 0, rd);
    chk("lw1", rd, 32'hDEAD_BEEF);
    run(1'b1, 3'd1, 32'hA, 32'h0000_1111, 0, rd);
    run(1'b0, 3'd2, 32'h8, 32'd0, 0, rd);
    chk("lw2", rd, 32'h1111_BEEF);

    run(1'b0, 3'd2, 32'h6, 32'd0, 0, rd);
    run(1'b1, 3'd1, 32'h1, 32'h5555, 0, rd);
    run(1'b0, 3'd3, 32'h0, 32'd0, 0, rd);
    run(1'b1, 3'd4, 32'h0, 32'h7777, 0, rd);

    run(1'b0, 3'd2, 32'h8, 32'd0, 5, rd);

    // reset during ISSUE of a store
    req_valid = 1'b1;
    req_store = 1'b1;
    req_funct3 = 3'd2;
    req_address = 32'h20;
    req_wdata = 32'hCAFE_F00D;
    step();
    req_valid = 1'b0;
    chk("rs_issue", 32'(mem_wren), 32'd1);
    for (int k = 0; k < 4; k++)
      refm[32 + k] = req_wdata[8*k +: 8];
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_vals("rst_st");
    step();
    chk("rst_st_nv", 32'(resp_valid), 32'd0);

    // reset during WAIT of a load
    req_valid = 1'b1;
    req_store = 1'b0;
    req_funct3 = 3'd2;
    req_address = 32'h24;
    step();
    req_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_vals("rst_ld");
    step();
    chk("rst_ld_nv", 32'(resp_valid), 32'd0);
    run(1'b0, 3'd2, 32'h20, 32'd0, 0, rd);
    chk("after_rst", rd, 32'hCAFE_F00D);

    for (int t = 0; t < 200; t++) begin
      bit st = $urandom_range(0, 1) == 1;
      int ix = $urandom_range(0, 9);
      logic [2:0] f3 = (ix < 8) ? f3tab[ix] : 3'd2;
      logic [31:0] a = 32'($urandom_range(0, 255));
      int hold = ($urandom_range(0, 3) == 0) ?
                 $urandom_range(1, 3) : 0;
      if ($urandom_range(0, 3) != 0)
        a = a & ~32'(size_of(f3) - 1);
      run(st, f3, a, $urandom, hold, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp, err);
    $finish;
  end

endmodule
